// File: rtl/sram_arbiter_pkg.sv
// Shared types and defaults for the SRAM port arbiter.
package sram_arbiter_pkg;

    localparam int DEF_ACCESS_CYCLES = 2;
    localparam int DEF_STARVE_LIMIT  = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_TURN   = 2'd2
    } arb_state_t;

    // Bits needed to hold 0..max_val, never less than one.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sram_arb_slot.sv
// One-entry CPU request buffer; a strobe arriving while the entry is occupied is dropped and flagged.
module sram_arb_slot #(
    parameter int ADDR_W = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        data,
    input  logic              rd,
    input  logic              wr,
    input  logic              pop,
    output logic              vld,
    output logic [ADDR_W-1:0] req_addr,
    output logic [7:0]        req_data,
    output logic              req_wr,
    output logic              ovf
);

    logic strobe;
    assign strobe = rd | wr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld      <= 1'b0;
            req_addr <= '0;
            req_data <= '0;
            req_wr   <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            ovf <= 1'b0;
            // A pop on the same edge frees the entry, so the new strobe refills it.
            if (strobe && (!vld || pop)) begin
                vld      <= 1'b1;
                req_addr <= addr;
                req_data <= data;
                req_wr   <= wr;
            end else if (strobe) begin
                ovf <= 1'b1;
            end else if (pop) begin
                vld <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Shares the single external SRAM port between the CPU bridge and video fetch; CPU has priority
// but video is forced after STARVE_LIMIT consecutive CPU grants while it waits.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int ADDR_W        = 20,
    parameter int ACCESS_CYCLES = DEF_ACCESS_CYCLES,
    parameter int STARVE_LIMIT  = DEF_STARVE_LIMIT
) (
    input  logic              iClk,
    input  logic              iReset,
    input  logic [ADDR_W-1:0] iCpuAddr,
    input  logic [7:0]        iCpuData,
    input  logic              iCpuRd,
    input  logic              iCpuWr,
    output logic [7:0]        oCpuData,
    output logic              oCpuRdValid,
    output logic              oCpuBusy,
    output logic              oCpuOvf,
    input  logic              iVidReq,
    input  logic [ADDR_W-1:0] iVidAddr,
    output logic              oVidAck,
    output logic [7:0]        oVidData,
    output logic [ADDR_W-1:0] oSramA,
    output logic [7:0]        oSramD,
    input  logic [7:0]        iSramD,
    output logic              oSramDir,
    output logic              oSramOe,
    output logic              oSramWe
);

    localparam int CNT_W = cnt_width(ACCESS_CYCLES);
    localparam int SV_W  = cnt_width(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_INIT   = CNT_W'(ACCESS_CYCLES);
    localparam logic [SV_W-1:0]  STARVE_MAX = SV_W'(STARVE_LIMIT);

    arb_state_t        state;
    logic [CNT_W-1:0]  cnt;
    logic [SV_W-1:0]   starve;
    logic              cur_vid;
    logic              cur_wr;

    logic              slot_vld;
    logic [ADDR_W-1:0] slot_addr;
    logic [7:0]        slot_data;
    logic              slot_wr;
    logic              slot_pop;
    logic              force_vid;
    logic              vid_pick;

    sram_arb_slot #(.ADDR_W(ADDR_W)) u_slot (
        .clk      (iClk),
        .rst_n    (iReset),
        .addr     (iCpuAddr),
        .data     (iCpuData),
        .rd       (iCpuRd),
        .wr       (iCpuWr),
        .pop      (slot_pop),
        .vld      (slot_vld),
        .req_addr (slot_addr),
        .req_data (slot_data),
        .req_wr   (slot_wr),
        .ovf      (oCpuOvf)
    );

    assign oCpuBusy  = slot_vld;
    assign force_vid = (STARVE_LIMIT > 0) && iVidReq && (starve == STARVE_MAX);
    assign slot_pop  = (state == ST_IDLE) && slot_vld && !force_vid;
    assign vid_pick  = (state == ST_IDLE) && iVidReq && (!slot_vld || force_vid);

    always_ff @(posedge iClk or negedge iReset) begin
        if (!iReset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            starve      <= '0;
            cur_vid     <= 1'b0;
            cur_wr      <= 1'b0;
            oSramA      <= '0;
            oSramD      <= '0;
            oSramDir    <= 1'b0;
            oSramOe     <= 1'b1;
            oSramWe     <= 1'b1;
            oCpuData    <= '0;
            oCpuRdValid <= 1'b0;
            oVidData    <= '0;
            oVidAck     <= 1'b0;
        end else begin
            oCpuRdValid <= 1'b0;
            oVidAck     <= 1'b0;
            if (!iVidReq)
                starve <= '0;
            case (state)
                ST_IDLE: begin
                    if (slot_pop || vid_pick) begin
                        state   <= ST_ACCESS;
                        cnt     <= CNT_INIT;
                        cur_vid <= !slot_pop;
                        cur_wr  <= slot_pop && slot_wr;
                        oSramA  <= slot_pop ? slot_addr : iVidAddr;
                        if (slot_pop && slot_wr) begin
                            oSramD   <= slot_data;
                            oSramDir <= 1'b1;
                            oSramWe  <= 1'b0;
                        end else begin
                            oSramDir <= 1'b0;
                            oSramOe  <= 1'b0;
                        end
                        if (!slot_pop || !iVidReq)
                            starve <= '0;
                        else if (starve != STARVE_MAX)
                            starve <= starve + 1'b1;
                    end
                end
                ST_ACCESS: begin
                    if (cnt == CNT_W'(1)) begin
                        if (!cur_wr) begin
                            if (cur_vid) begin
                                oVidData <= iSramD;
                                oVidAck  <= 1'b1;
                            end else begin
                                oCpuData    <= iSramD;
                                oCpuRdValid <= 1'b1;
                            end
                        end
                        oSramOe <= 1'b1;
                        oSramWe <= 1'b1;
                        state   <= ST_TURN;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_TURN: begin
                    // Bus turnaround cycle: release the data drivers before any new grant.
                    oSramDir <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
